// File: rtl/shift_job_sequencer.sv
// rtl/shift_job_sequencer.sv - operand FIFO and start/done job sequencer for the shift engine
//
// Purpose:
//   Queues operand pairs in a small FIFO and issues them one at a time to
//   the shift engine (start pulse, operands held until done). Captures the
//   engine result into a valid/ready output register and raises a sticky
//   error if the engine never reports done.
//
// Ports:
//   clk                                  rising-edge clock
//   rst                                  asynchronous reset, active low
//   in_valid / in_ready / in_a / in_b    operand pair stream into the FIFO
//   eng_start / eng_a / eng_b            job issue towards the engine
//   eng_done / eng_result                engine completion pulse and result
//   out_valid / out_ready / out_result   held result towards downstream
//   busy                                 job active or FIFO non-empty
//   err                                  sticky watchdog flag
module shift_job_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               eng_start,
  output logic [WIDTH-1:0]   eng_a,
  output logic [WIDTH-1:0]   eng_b,
  input  logic               eng_done,
  input  logic [2*WIDTH-1:0] eng_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               busy,
  output logic               err
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);
  localparam logic [WDW-1:0] WD_MAX     = WDW'(TIMEOUT);
  // The counter holds k during the (k+1)-th WAIT cycle, so the edge that
  // ends the TIMEOUT-th WAIT cycle is the one seen while it holds TIMEOUT-1.
  localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]   r_mem_a [DEPTH];
  logic [WIDTH-1:0]   r_mem_b [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic [WDW-1:0]     r_wdog;
  logic [WIDTH-1:0]   r_eng_a;
  logic [WIDTH-1:0]   r_eng_b;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_out_result;
  logic               r_err;

  logic w_empty;
  logic w_push;
  logic w_issue_ok;
  logic w_pop;
  logic w_capture;
  logic w_timeout;

  // in_ready comes from the registered count only, so a pop in a full
  // cycle does not open the input until the following cycle.
  assign in_ready   = (r_count != FULL_COUNT);
  assign w_empty    = (r_count == '0);
  assign w_push     = in_valid && in_ready;
  // Never start a job while an unconsumed result could be overwritten.
  assign w_issue_ok = !w_empty && (!r_out_valid || out_ready);
  assign w_pop      = (r_state == S_IDLE) && w_issue_ok;
  // Done outside WAIT is a stray pulse and is ignored.
  assign w_capture  = (r_state == S_WAIT) && eng_done;
  // A done on the final permitted WAIT cycle still wins over the watchdog.
  assign w_timeout  = (r_state == S_WAIT) && !eng_done && (r_wdog >= WD_LAST);

  assign eng_a      = r_eng_a;
  assign eng_b      = r_eng_b;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign err        = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    eng_start   = 1'b0;
    busy        = !w_empty;
    case (r_state)
      S_IDLE: begin
        if (w_issue_ok) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start   = 1'b1;
        busy        = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (eng_done || w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wptr] <= in_a;
      r_mem_b[r_wptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Operands move only on the IDLE->ISSUE edge and then stay put for the
  // whole job, including the engine's own init cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_eng_a <= '0;
      r_eng_b <= '0;
    end else if (w_pop) begin
      r_eng_a <= r_mem_a[r_rptr];
      r_eng_b <= r_mem_b[r_rptr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_wdog <= '0;
      end else if (r_state == S_WAIT) begin
        if (eng_done) begin
          r_wdog <= '0;
        end else if (r_wdog != WD_MAX) begin
          r_wdog <= r_wdog + WDW'(1);
        end
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
    end else begin
      if (w_capture) begin
        r_out_valid  <= 1'b1;
        r_out_result <= eng_result;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_job_sequencer.sv
// tb/tb_shift_job_sequencer.sv - self-checking bench for shift_job_sequencer
module tb_shift_job_sequencer;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               eng_start;
  logic [WIDTH-1:0]   eng_a;
  logic [WIDTH-1:0]   eng_b;
  logic               eng_done;
  logic [2*WIDTH-1:0] eng_result;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_result;
  logic               busy;
  logic               err;

  shift_job_sequencer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: pairs accepted but not yet started (push order),
  // results owed to downstream (completion order), and the engine model.
  logic [WIDTH-1:0]   exp_a[$];
  logic [WIDTH-1:0]   exp_b[$];
  logic [2*WIDTH-1:0] res_q[$];
  logic [WIDTH-1:0]   ja;
  logic [WIDTH-1:0]   jb;
  logic [2*WIDTH-1:0] res_tmp;
  int  eng_cnt;
  int  eng_lat   = 4;
  bit  eng_mute  = 1'b0;
  int  stray_cnt = 0;
  int  stray_seen;
  int  cyc;
  int  start_cnt;
  int  done_cyc;
  bit  gap_armed;
  bit  gap_chk   = 1'b0;
  bit  prev_start;

  // Engine model plus scoreboard, evaluated mid-cycle after stimulus settles.
  initial begin
    eng_done = 1'b0; eng_result = '0;
    ja = '0; jb = '0; eng_cnt = 0; stray_seen = 0; cyc = 0; start_cnt = 0;
    done_cyc = 0; gap_armed = 1'b0; prev_start = 1'b0;
    forever begin
      @(posedge clk); #4;
      cyc++;
      eng_done = 1'b0;
      if (!rst) begin
        exp_a.delete(); exp_b.delete(); res_q.delete();
        ja = '0; jb = '0; eng_cnt = 0; prev_start = 1'b0; gap_armed = 1'b0;
        stray_seen = stray_cnt;
      end else begin
        if (in_valid && in_ready) begin
          exp_a.push_back(in_a);
          exp_b.push_back(in_b);
        end
        if (out_valid && out_ready) begin
          check("result_owed", res_q.size() != 0, 1);
          if (res_q.size() != 0) begin
            res_tmp = res_q.pop_front();
            check("out_result", out_result, res_tmp);
          end
        end
        if (stray_seen != stray_cnt) begin
          stray_seen = stray_cnt;
          eng_done   = 1'b1;
          eng_result = $urandom;
        end else if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            eng_done   = 1'b1;
            eng_result = {16'b0, ja} * {16'b0, jb};
            res_q.push_back(eng_result);
            done_cyc   = cyc;
            gap_armed  = (exp_a.size() != 0);
          end
        end
        if (eng_start) begin
          start_cnt++;
          check("start_one_cycle", prev_start, 0);
          check("one_in_flight", eng_cnt, 0);
          check("start_has_job", exp_a.size() != 0, 1);
          if (exp_a.size() != 0) begin
            ja = exp_a.pop_front();
            jb = exp_b.pop_front();
            check("issue_a", eng_a, ja);
            check("issue_b", eng_b, jb);
          end
          if (gap_chk && gap_armed) begin
            check("b2b_gap", cyc - done_cyc, 2);
          end
          gap_armed = 1'b0;
          if (!eng_mute) begin
            eng_cnt = (eng_lat > 0) ? eng_lat : int'($urandom_range(1, 7));
          end
        end else begin
          check("hold_a", eng_a, ja);
          check("hold_b", eng_b, jb);
        end
        prev_start = eng_start;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int waited);
    in_valid = 1'b1; in_a = a; in_b = b; waited = 0;
    while (!in_ready && waited < 200) begin
      step(1);
      waited++;
    end
    check("push_timeout", waited >= 200, 0);
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || out_valid) && k < 2000) begin
      step(1);
      k++;
    end
    check("idle_timeout", k >= 2000, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   in_ready,   1);
    check({tag, "_eng_start"},  eng_start,  0);
    check({tag, "_eng_a"},      eng_a,      0);
    check({tag, "_eng_b"},      eng_b,      0);
    check({tag, "_out_valid"},  out_valid,  0);
    check({tag, "_out_result"}, out_result, 0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_err"},        err,        0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int k;
    int sc;
    logic [WIDTH-1:0] pa [6];
    logic [WIDTH-1:0] pb [6];

    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    step(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    step(1);

    // Single job: 3*5 with a four-cycle engine.
    out_ready = 1'b1; eng_lat = 4;
    push(16'd3, 16'd5, w);
    check("single_push_wait", w, 0);
    check("single_queued_busy", busy, 1);
    check("single_queued_nostart", eng_start, 0);
    step(1);
    check("single_start", eng_start, 1);
    check("single_eng_a", eng_a, 3);
    check("single_eng_b", eng_b, 5);
    step(1);
    check("single_start_low", eng_start, 0);
    step(3);
    check("single_no_early_valid", out_valid, 0);
    step(1);
    check("single_out_valid", out_valid, 1);
    check("single_out_result", out_result, 15);
    step(1);
    check("single_consumed", out_valid, 0);
    check("single_not_busy", busy, 0);

    // FIFO full: slow engine, six pairs pushed back-to-back.
    eng_lat = 7;
    for (int i = 0; i < 5; i++) begin
      push(16'($urandom), 16'($urandom), w);
      check("full_push_wait", w, 0);
    end
    check("full_in_ready_low", in_ready, 0);
    check("full_busy", busy, 1);
    push(16'($urandom), 16'($urandom), w);
    check("full_sixth_wait", w, 6);
    wait_idle();
    check("full_no_err", err, 0);

    // Output backpressure: second job must wait for the first result to drain.
    eng_lat = 2; out_ready = 1'b0;
    pa[0] = 16'h1234; pb[0] = 16'h0011; pa[1] = 16'h00ff; pb[1] = 16'h0101;
    push(pa[0], pb[0], w);
    push(pa[1], pb[1], w);
    step(4);
    sc = start_cnt;
    step(8);
    check("bp_no_issue", start_cnt - sc, 0);
    check("bp_held_valid", out_valid, 1);
    check("bp_held_result", out_result, 32'h1234 * 32'h0011);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("bp_issue_after_release", eng_start, 1);
    check("bp_released", out_valid, 0);
    step(4);
    check("bp_second_valid", out_valid, 1);
    check("bp_second_result", out_result, 32'h00ff * 32'h0101);
    out_ready = 1'b1;
    wait_idle();

    // Simultaneous push and pop with two entries queued.
    eng_lat = 3; gap_chk = 1'b1;
    for (int i = 0; i < 3; i++) push(16'($urandom), 16'($urandom), w);
    k = 0;
    while (!eng_done && k < 50) begin
      step(1);
      k++;
    end
    check("sim_done_timeout", k >= 50, 0);
    push(16'($urandom), 16'($urandom), w);
    check("sim_push_on_pop", w, 0);
    check("sim_next_start", eng_start, 1);
    push(16'($urandom), 16'($urandom), w);
    check("sim_push5", w, 0);
    push(16'($urandom), 16'($urandom), w);
    check("sim_push6", w, 0);
    check("sim_full_after", in_ready, 0);
    wait_idle();
    gap_chk = 1'b0;

    // Watchdog: engine never answers.
    eng_mute = 1'b1;
    push(16'($urandom), 16'($urandom), w);
    push(16'($urandom), 16'($urandom), w);
    k = 0;
    while (!eng_start && k < 50) begin
      step(1);
      k++;
    end
    check("wd_start_timeout", k >= 50, 0);
    step(8);
    check("wd_err_not_yet", err, 0);
    step(1);
    check("wd_err_set", err, 1);
    check("wd_no_result", out_valid, 0);
    stray_cnt++;
    step(1);
    check("wd_next_issue", eng_start, 1);
    check("wd_stray_ignored", out_valid, 0);
    step(1);
    check("wd_stray_ignored2", out_valid, 0);
    wait_idle();
    check("wd_err_sticky", err, 1);

    // Reset mid-job with two entries still queued.
    push(16'hA5A5, 16'h5A5A, w);
    push(16'h0F0F, 16'h00F0, w);
    push(16'h1111, 16'h2222, w);
    step(2);
    check("rst_in_wait_busy", busy, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    step(2);
    rst = 1'b1;
    sc = start_cnt;
    step(10);
    check("rst_no_start", start_cnt - sc, 0);
    check("rst_idle", busy, 0);

    // Random traffic against the model.
    eng_mute = 1'b0; eng_lat = 0;
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();
    check("rand_results_drained", res_q.size(), 0);
    check("rand_jobs_drained", exp_a.size(), 0);
    check("rand_no_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
